// File: rtl/demux_stream_n_ch.sv
// Registered 1-to-M stream demux: one output register per channel,
// so a stalled consumer only blocks words aimed at its own channel.
module demux_stream_n_ch #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   a,
  input  logic [$clog2(M)-1:0] s,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M*N-1:0] z,
  output logic [M-1:0]   out_valid,
  input  logic [M-1:0]   out_ready,
  output logic           err,
  input  logic           err_clr
);

  localparam int SW = $clog2(M);
  localparam logic [SW:0] LM = (SW+1)'(M);

  logic         w_legal;
  logic         w_acc;
  logic         w_bad_acc;
  logic [M-1:0] w_hit;
  logic [M-1:0] w_free;
  logic         r_err;

  // Out-of-range selects are always consumed so they cannot wedge the input.
  assign w_legal   = ({1'b0, s} < LM);
  assign in_ready  = !w_legal | (|(w_hit & w_free));
  assign w_acc     = in_valid & in_ready;
  assign w_bad_acc = w_acc & !w_legal;

  genvar g;
  for (g = 0; g < M; g++) begin : g_ch
    logic [N-1:0] r_d;
    logic         r_v;

    assign w_hit[g]  = w_legal & (s == SW'(g));
    assign w_free[g] = !r_v | out_ready[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_d <= '0;
        r_v <= 1'b0;
      end else if (w_acc & w_hit[g]) begin
        r_d <= a;
        r_v <= 1'b1;
      end else if (out_ready[g]) begin
        r_v <= 1'b0;
      end
    end

    assign z[g*N +: N]  = r_d;
    assign out_valid[g] = r_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad_acc) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_demux_stream_n_ch.sv
// Bench for demux_stream_n_ch: vector table on M=4, corner sequences,
// and random traffic on M=3 against a queue-based reference model.
module tb_demux_stream_n_ch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a4 = '0;
  logic [1:0]  s4 = '0;
  logic        iv4 = 1'b0;
  logic        rdy4;
  logic [31:0] z4;
  logic [3:0]  ov4;
  logic [3:0]  or4 = '0;
  logic        err4;
  logic        clr4 = 1'b0;

  logic [7:0]  a3 = '0;
  logic [1:0]  s3 = '0;
  logic        iv3 = 1'b0;
  logic        rdy3;
  logic [23:0] z3;
  logic [2:0]  ov3;
  logic [2:0]  or3 = '0;
  logic        err3;
  logic        clr3 = 1'b0;

  demux_stream_n_ch #(.N(8), .M(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .s(s4),
    .in_valid(iv4), .in_ready(rdy4), .z(z4),
    .out_valid(ov4), .out_ready(or4),
    .err(err4), .err_clr(clr4)
  );

  demux_stream_n_ch #(.N(8), .M(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .s(s3),
    .in_valid(iv3), .in_ready(rdy3), .z(z3),
    .out_valid(ov3), .out_ready(or3),
    .err(err3), .err_clr(clr3)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [1:0]  s;
    logic        iv;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic [31:0] z;
  } vec_t;

  vec_t tv [9];

  logic [7:0] q [3][$];
  logic [7:0] last [3];
  logic       merr;

  initial begin
    tv[0] = '{8'hA5, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A5_0000};
    tv[1] = '{8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h00A5_0000};
    tv[2] = '{8'h11, 2'd1, 1'b1, 4'b1101, 1'b1, 4'b0010, 32'h00A5_1100};
    tv[3] = '{8'h22, 2'd1, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h00A5_1100};
    tv[4] = '{8'h22, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h00A5_2200};
    tv[5] = '{8'h44, 2'd0, 1'b1, 4'b1110, 1'b1, 4'b0001, 32'h00A5_2244};
    tv[6] = '{8'h33, 2'd3, 1'b1, 4'b1110, 1'b1, 4'b1001, 32'h33A5_2244};
    tv[7] = '{8'h55, 2'd0, 1'b1, 4'b0110, 1'b0, 4'b1001, 32'h33A5_2244};
    tv[8] = '{8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h33A5_2244};

    // reset state
    #12;
    chk("rst_ov4", 64'(ov4), 64'd0);
    chk("rst_z4", 64'(z4), 64'd0);
    chk("rst_rdy4", 64'(rdy4), 64'd1);
    chk("rst_err3", 64'(err3), 64'd0);
    chk("rst_rdy3", 64'(rdy3), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // vector table on M=4
    for (int i = 0; i < 9; i++) begin
      a4 = tv[i].a; s4 = tv[i].s; iv4 = tv[i].iv; or4 = tv[i].ordy;
      #1;
      chk($sformatf("tv%0d_rdy", i), 64'(rdy4), 64'(tv[i].rdy));
      tick();
      chk($sformatf("tv%0d_ov", i), 64'(ov4), 64'(tv[i].ov));
      chk($sformatf("tv%0d_z", i), 64'(z4), 64'(tv[i].z));
    end
    chk("err4", 64'(err4), 64'd0);

    // back-to-back into channel 0
    for (int i = 1; i <= 8; i++) begin
      a4 = 8'(i); s4 = 2'd0; iv4 = 1'b1; or4 = 4'b1111;
      #1;
      chk($sformatf("b2b%0d_rdy", i), 64'(rdy4), 64'd1);
      tick();
      chk($sformatf("b2b%0d_z", i), 64'(z4[7:0]), 64'(i));
      chk($sformatf("b2b%0d_ov", i), 64'(ov4), 64'd1);
    end
    iv4 = 1'b0;
    tick();
    chk("b2b_end_ov", 64'(ov4), 64'd0);

    // illegal select on M=3
    a3 = 8'hFF; s3 = 2'd3; iv3 = 1'b1; or3 = 3'b111;
    #1;
    chk("ill_rdy", 64'(rdy3), 64'd1);
    tick();
    chk("ill_ov", 64'(ov3), 64'd0);
    chk("ill_z", 64'(z3), 64'd0);
    chk("ill_err", 64'(err3), 64'd1);
    iv3 = 1'b0; clr3 = 1'b1;
    tick();
    chk("clr_err", 64'(err3), 64'd0);
    iv3 = 1'b1; clr3 = 1'b1;
    tick();
    chk("setwins_err", 64'(err3), 64'd1);
    iv3 = 1'b0; clr3 = 1'b0;

    // async reset with channels 0,1,3 full and stalled
    or4 = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        a4 = 8'h10 + 8'(k); s4 = 2'(k); iv4 = 1'b1;
        tick();
      end
    end
    iv4 = 1'b0;
    chk("pre_rst_ov", 64'(ov4), 64'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(ov4), 64'd0);
    chk("arst_z", 64'(z4), 64'd0);
    chk("arst_err3", 64'(err3), 64'd0);
    chk("arst_rdy4", 64'(rdy4), 64'd1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // random traffic on M=3 against queue model
    for (int k = 0; k < 3; k++) last[k] = '0;
    merr = 1'b0;
    begin
      logic hold;
      logic erdy;
      logic acc;
      logic [2:0]  eov;
      logic [23:0] ez;
      hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (!hold) begin
          a3 = 8'($urandom);
          s3 = 2'($urandom_range(0, 3));
          iv3 = ($urandom_range(0, 9) < 7);
        end
        or3 = 3'($urandom);
        clr3 = ($urandom_range(0, 7) == 0);
        #1;
        erdy = (s3 == 2'd3) ? 1'b1
             : (q[s3].size() == 0 || or3[s3]);
        chk("rnd_rdy", 64'(rdy3), 64'(erdy));
        acc = iv3 & erdy;
        tick();
        for (int k = 0; k < 3; k++)
          if (or3[k] && q[k].size() != 0) void'(q[k].pop_front());
        if (acc && s3 != 2'd3) begin
          q[s3].push_back(a3);
          last[s3] = a3;
        end
        if (acc && s3 == 2'd3) merr = 1'b1;
        else if (clr3) merr = 1'b0;
        hold = iv3 & !erdy;
        for (int k = 0; k < 3; k++) begin
          eov[k] = (q[k].size() != 0);
          ez[k*8 +: 8] = last[k];
        end
        chk("rnd_ov", 64'(ov3), 64'(eov));
        chk("rnd_z", 64'(z3), 64'(ez));
        chk("rnd_err", 64'(err3), 64'(merr));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
